// File: rtl/core_parity_gen_if.sv
// Handshake and data bundle between the information-column feeder, the core
// parity generator and the downstream extension-parity selection muxes.
interface core_parity_gen_if #(
    parameter int MAX_ZC    = 384,
    parameter int CORE_ROWS = 4
);
    logic                               start;
    logic                               bg_sel;
    logic [8:0]                         zc;
    logic [4:0]                         kb;
    logic [8:0]                         core_shift;
    logic                               in_valid;
    logic                               in_ready;
    logic [CORE_ROWS-1:0][MAX_ZC-1:0]   in_row_terms;
    logic [CORE_ROWS-1:0][MAX_ZC-1:0]   parity_blocks;
    logic                               parity_valid;
    logic                               parity_ready;
    logic                               busy;
    logic                               cfg_err;

    modport master (
        output start, bg_sel, zc, kb, core_shift, in_valid, in_row_terms, parity_ready,
        input  in_ready, parity_blocks, parity_valid, busy, cfg_err
    );

    modport slave (
        input  start, bg_sel, zc, kb, core_shift, in_valid, in_row_terms, parity_ready,
        output in_ready, parity_blocks, parity_valid, busy, cfg_err
    );
endinterface

// File: rtl/core_parity_gen.sv
// Core-row syndrome accumulation and double-diagonal solve for parity blocks p0..p3.
// One job per start; results are held in HOLD until downstream accepts them.
module core_parity_lane #(
    parameter int W = 384
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    input  logic [W-1:0] mask,
    output logic [W-1:0] lam
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      lam <= '0;
        else if (clr) lam <= '0;
        else if (en)  lam <= lam ^ (term & mask);
    end
endmodule

module core_parity_gen #(
    parameter int MAX_ZC    = 384,
    parameter int CORE_ROWS = 4,
    parameter int KB_MAX    = 22
) (
    input  logic              clk,
    input  logic              rst,
    core_parity_gen_if.slave  bus
);
    localparam logic [4:0] KB_MAX_W = 5'(KB_MAX);

    typedef enum logic [2:0] {IDLE, ACCUM, SOLVE0, SOLVE1, SOLVE2, HOLD} state_t;
    state_t state, state_nx;

    logic [CORE_ROWS-1:0][MAX_ZC-1:0] lam, p;
    logic [MAX_ZC-1:0] mask, rot_p0;
    logic [8:0]        zc_q, a_q;
    logic [4:0]        kb_q, cnt;
    logic              bg_q, err_q, beat, clr, start_err, kb_bad;

    assign beat      = (state == ACCUM) && bus.in_valid;
    assign clr       = (state == IDLE) && bus.start;
    assign kb_bad    = (bus.kb == 5'd0) || (bus.kb > KB_MAX_W);
    assign start_err = (bus.core_shift >= bus.zc) || kb_bad;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_ZC; i++) mask[i] = (10'(i) < {1'b0, zc_q});
    end

    // Shared rotator; relies on p0 being zero above zc and a < zc.
    always_comb begin
        rot_p0 = ((p[0] >> a_q) | (p[0] << (zc_q - a_q))) & mask;
    end

    for (genvar r = 0; r < CORE_ROWS; r++) begin : g_lane
        core_parity_lane #(.W(MAX_ZC)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .en   (beat),
            .term (bus.in_row_terms[r]),
            .mask (mask),
            .lam  (lam[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = ACCUM;
            ACCUM:   if (beat && (cnt + 5'd1 == kb_q)) state_nx = SOLVE0;
            SOLVE0:  state_nx = SOLVE1;
            SOLVE1:  state_nx = SOLVE2;
            SOLVE2:  state_nx = HOLD;
            HOLD:    if (bus.parity_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_q  <= 1'b0;
            zc_q  <= '0;
            a_q   <= '0;
            kb_q  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    bg_q  <= bus.bg_sel;
                    zc_q  <= bus.zc;
                    a_q   <= start_err ? 9'd0 : bus.core_shift;
                    kb_q  <= kb_bad ? KB_MAX_W : bus.kb;
                    cnt   <= '0;
                    err_q <= start_err;
                end
                ACCUM:  if (beat) cnt <= cnt + 5'd1;
                SOLVE0: p[0] <= lam[0] ^ lam[1] ^ lam[2] ^ lam[3];
                SOLVE1: begin
                    p[1] <= lam[0] ^ rot_p0;
                    p[3] <= lam[3] ^ rot_p0;
                end
                SOLVE2: p[2] <= bg_q ? (lam[2] ^ p[3]) : (lam[1] ^ p[0] ^ p[1]);
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = (state == ACCUM);
    assign bus.parity_valid  = (state == HOLD);
    assign bus.busy          = (state != IDLE);
    assign bus.cfg_err       = err_q;
    assign bus.parity_blocks = p;
endmodule

// File: tb/tb_core_parity_gen.sv
// Directed bench for core_parity_gen with a spec-level parity model and a
// per-cycle compare process on held parity outputs and cfg_err.
module tb_core_parity_gen;
    localparam int MAX_ZC = 384;
    localparam int CR     = 4;
    localparam int KB_MAX = 22;
    typedef logic [CR-1:0][MAX_ZC-1:0] blk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    blk_t exp_p = '0;
    logic exp_err = 1'b0;
    blk_t q_beats[$];

    core_parity_gen_if #(.MAX_ZC(MAX_ZC), .CORE_ROWS(CR)) bus();

    core_parity_gen #(.MAX_ZC(MAX_ZC), .CORE_ROWS(CR), .KB_MAX(KB_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [MAX_ZC-1:0] z(input logic [31:0] v);
        z = '0;
        z[31:0] = v;
    endfunction

    task automatic chk(input string name, input logic [MAX_ZC-1:0] act, input logic [MAX_ZC-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Spec-level model: xor the beats, mask to zc, then solve the core.
    function automatic blk_t model(input bit bg, input int zc, input int a);
        blk_t lam, p;
        logic [MAX_ZC-1:0] rp;
        lam = '0;
        foreach (q_beats[b]) lam ^= q_beats[b];
        for (int r = 0; r < CR; r++)
            for (int i = zc; i < MAX_ZC; i++) lam[r][i] = 1'b0;
        p = '0;
        p[0] = lam[0] ^ lam[1] ^ lam[2] ^ lam[3];
        rp = '0;
        for (int i = 0; i < zc; i++) rp[i] = p[0][(i + a) % zc];
        p[1] = lam[0] ^ rp;
        p[3] = lam[3] ^ rp;
        p[2] = bg ? (lam[2] ^ p[3]) : (lam[1] ^ p[0] ^ p[1]);
        return p;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.parity_valid)
                for (int r = 0; r < CR; r++)
                    chk($sformatf("p%0d", r), bus.parity_blocks[r], exp_p[r]);
            if (bus.busy) chk("cfg_err", MAX_ZC'(bus.cfg_err), MAX_ZC'(exp_err));
        end
    end

    task automatic do_start(input bit bg, input int zc, input int kb, input int sh);
        bit err;
        int ekb;
        err = (sh >= zc) || (kb == 0) || (kb > KB_MAX);
        ekb = (kb == 0 || kb > KB_MAX) ? KB_MAX : kb;
        exp_err = err;
        if (q_beats.size() == ekb) exp_p = model(bg, zc, err ? 0 : sh);
        bus.bg_sel = bg;
        bus.zc = 9'(zc);
        bus.kb = 5'(kb);
        bus.core_shift = 9'(sh);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input blk_t t);
        int cyc;
        bus.in_valid = 1'b1;
        bus.in_row_terms = t;
        cyc = 0;
        @(negedge clk);
        while (!bus.in_ready && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("in_ready_beat", MAX_ZC'(bus.in_ready), MAX_ZC'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input bit bg, input int zc, input int kb, input int sh,
                           input int gap, input int hold);
        int cyc;
        do_start(bg, zc, kb, sh);
        foreach (q_beats[b]) begin
            if (b > 0) repeat (gap) begin @(posedge clk); #1; end
            send_beat(q_beats[b]);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("in_ready_drop", MAX_ZC'(bus.in_ready), MAX_ZC'(0));
        end while (!bus.parity_valid && cyc < 20);
        chk("latency", z(32'(cyc)), z(4));
        // Stray beats and start pulses during HOLD must have no effect.
        bus.in_valid = 1'b1;
        bus.in_row_terms = {CR{ {(MAX_ZC/32){32'hDEADBEEF}} }};
        bus.start = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", MAX_ZC'(bus.parity_valid), MAX_ZC'(1));
        end
        bus.parity_ready = 1'b1;
        @(posedge clk); #1;
        bus.parity_ready = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", MAX_ZC'(bus.busy), MAX_ZC'(0));
        chk("idle_valid", MAX_ZC'(bus.parity_valid), MAX_ZC'(0));
    endtask

    task automatic lit4(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3);
        chk({tag, "_p0"}, bus.parity_blocks[0], z(a0));
        chk({tag, "_p1"}, bus.parity_blocks[1], z(a1));
        chk({tag, "_p2"}, bus.parity_blocks[2], z(a2));
        chk({tag, "_p3"}, bus.parity_blocks[3], z(a3));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        blk_t t;
        bus.start = 1'b0; bus.bg_sel = 1'b0; bus.zc = '0; bus.kb = '0; bus.core_shift = '0;
        bus.in_valid = 1'b0; bus.in_row_terms = '0; bus.parity_ready = 1'b0;
        #12;
        chk("rst_in_ready", MAX_ZC'(bus.in_ready), MAX_ZC'(0));
        chk("rst_valid", MAX_ZC'(bus.parity_valid), MAX_ZC'(0));
        chk("rst_busy", MAX_ZC'(bus.busy), MAX_ZC'(0));
        chk("rst_err", MAX_ZC'(bus.cfg_err), MAX_ZC'(0));
        for (int r = 0; r < CR; r++) chk("rst_blocks", bus.parity_blocks[r], '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // BG1 and BG2 with a=1, zc=8
        t = '0; t[0] = z(1); t[1] = z(2); t[2] = z(4); t[3] = z(8);
        q_beats = '{t};
        run_job(1'b0, 8, 1, 1, 0, 0);
        chk("model_p0", exp_p[0], z(32'h0F));
        chk("model_p1", exp_p[1], z(32'h86));
        chk("model_p2", exp_p[2], z(32'h8B));
        chk("model_p3", exp_p[3], z(32'h8F));
        lit4("bg1", 32'h0F, 32'h86, 32'h8B, 32'h8F);
        run_job(1'b1, 8, 1, 1, 0, 0);
        lit4("bg2", 32'h0F, 32'h86, 32'h8B, 32'h8F);

        // kb=3 with gaps, long HOLD stall
        q_beats.delete();
        t = '0; t[0] = z(32'hFF); q_beats.push_back(t); q_beats.push_back(t);
        t[0] = z(1); q_beats.push_back(t);
        run_job(1'b0, 8, 3, 0, 2, 10);
        lit4("gap", 32'h01, 32'h00, 32'h01, 32'h01);

        // core_shift >= zc forces a=0
        t = '0; t[0] = z(1);
        q_beats = '{t};
        run_job(1'b0, 16, 1, 20, 0, 1);
        lit4("shift_err", 32'h01, 32'h00, 32'h01, 32'h01);
        chk("cfg_err_held", MAX_ZC'(bus.cfg_err), MAX_ZC'(1));

        // kb=0 clamps to 22 beats; bits above zc must be masked
        q_beats.delete();
        for (int b = 0; b < KB_MAX; b++) begin
            t = '0;
            t[b % 4][7:0] = 8'(b * 29 + 3);
            t[(b + 1) % 4][15:8] = 8'hA5;
            q_beats.push_back(t);
        end
        run_job(1'b1, 8, 0, 3, 0, 0);

        // full width zc=MAX_ZC, nonzero shift
        q_beats.delete();
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < CR; r++)
                for (int w = 0; w < MAX_ZC / 32; w++)
                    t[r][w*32 +: 32] = 32'(b * 32'h9E3779B9 + r * 32'h7F4A7C15 + w * 32'h01234567);
            q_beats.push_back(t);
        end
        run_job(1'b0, MAX_ZC, 4, 5, 1, 2);

        // partial zc with full-width dirty terms
        q_beats.delete();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < CR; r++)
                for (int w = 0; w < MAX_ZC / 32; w++)
                    t[r][w*32 +: 32] = 32'(32'hC3A5F00F ^ (b * 32'h1111) ^ (r * 32'h0F0F0F0F) ^ w);
            q_beats.push_back(t);
        end
        run_job(1'b1, 12, 2, 7, 0, 0);

        // reset in the middle of accumulation
        q_beats.delete();
        do_start(1'b0, 8, 3, 0);
        t = '0; t[0] = z(32'h3C); t[2] = z(32'h81);
        send_beat(t);
        send_beat(t);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", MAX_ZC'(bus.busy), MAX_ZC'(0));
        chk("midrst_in_ready", MAX_ZC'(bus.in_ready), MAX_ZC'(0));
        chk("midrst_valid", MAX_ZC'(bus.parity_valid), MAX_ZC'(0));
        for (int r = 0; r < CR; r++) chk("midrst_blocks", bus.parity_blocks[r], '0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        t = '0; t[1] = z(32'h10);
        q_beats = '{t};
        run_job(1'b0, 8, 1, 2, 0, 0);
        lit4("fresh", 32'h10, 32'h04, 32'h04, 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
